// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver on a 16x oversample tick.
// Start bit is qualified at its midpoint; data/stop sampled mid-bit.
module uart_rx_os16 #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 clk_50m,
  input  logic                 rstn,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OS_RATE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OS_RATE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OS_RATE - 1);
  localparam logic [2:0]    LAST    = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        os_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rdy_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 rx_m_q;
  logic                 rx_s_q;

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;

      if (rdy_clr) begin
        rdy_q <= 1'b0;
        ovr_q <= 1'b0;
      end

      // Completion below overrides the clear above on collision.
      if (rxclk_en) begin
        unique case (state_q)
          S_IDLE: begin
            if (!rx_s_q) begin
              state_q  <= S_START;
              os_cnt_q <= CW'(1);
            end
          end
          S_START: begin
            os_cnt_q <= os_cnt_q + 1'b1;
            if (os_cnt_q == HALF_M1) begin
              if (!rx_s_q) begin
                state_q   <= S_DATA;
                os_cnt_q  <= '0;
                bit_idx_q <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            os_cnt_q <= os_cnt_q + 1'b1;
            if (os_cnt_q == FULL_M1) begin
              shreg_q[bit_idx_q] <= rx_s_q;
              os_cnt_q  <= '0;
              bit_idx_q <= bit_idx_q + 1'b1;
              if (bit_idx_q == LAST) begin
                state_q <= S_STOP;
              end
            end
          end
          S_STOP: begin
            os_cnt_q <= os_cnt_q + 1'b1;
            if (os_cnt_q == FULL_M1) begin
              state_q <= S_IDLE;
              if (rx_s_q) begin
                data_q <= shreg_q;
                rdy_q  <= 1'b1;
                ferr_q <= 1'b0;
                if (rdy_q && !rdy_clr) begin
                  ovr_q <= 1'b1;
                end
              end else begin
                ferr_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed tests for the 8N1 oversampled receiver.
// Ticks come every DIV clocks; frames are driven tick-aligned.
module tb_uart_rx_os16;

  localparam int DIV = 4;

  logic       clk_50m = 1'b0;
  logic       rstn = 1'b0;
  logic       rxclk_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  logic [1:0] div = '0;

  uart_rx_os16 dut (
    .clk_50m  (clk_50m),
    .rstn     (rstn),
    .rxclk_en (rxclk_en),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    div = div + 1'b1;
    rxclk_en = (div == 2'd0);
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_50m);
      while (!rxclk_en) @(posedge clk_50m);
    end
    #1;
  endtask

  // Returns just after the tick that samples the stop bit (tick 152).
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic clr, output logic rdy_pre);
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(7);
    rdy_pre = rdy;
    if (clr) begin
      repeat (DIV - 1) @(posedge clk_50m);
      #1 rdy_clr = 1'b1;
      @(posedge clk_50m);
      #1 rdy_clr = 1'b0;
    end else begin
      wait_ticks(1);
    end
  endtask

  task automatic finish_stop();
    rx = 1'b1;
    wait_ticks(8);
  endtask

  task automatic pulse_clr();
    @(posedge clk_50m);
    #1 rdy_clr = 1'b1;
    @(posedge clk_50m);
    #1 rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_50m);
    checks++;
    if ({data, rdy, frame_err, overrun} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0",
               {data, rdy, frame_err, overrun});
    end
    #1 rstn = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_nominal();
    logic pre;
    send_frame(8'hA5, 1'b1, 1'b0, pre);
    checks++;
    if (pre !== 1'b0) begin
      errors++;
      $display("FAIL nominal_rdy_early: got %b, want 0", pre);
    end
    checks++;
    if (data !== 8'hA5 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_data: got %h rdy %b, want a5 rdy 1", data, rdy);
    end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL nominal_flags: got fe %b ov %b, want 0 0",
               frame_err, overrun);
    end
    finish_stop();
    pulse_clr();
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_clr: got rdy %b, want 0", rdy);
    end
  endtask

  task automatic test_glitch();
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    checks++;
    if (rdy !== 1'b0 || data !== 8'hA5 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_hold: got %h rdy %b fe %b, want a5 0 0",
               data, rdy, frame_err);
    end
  endtask

  task automatic test_frame_err();
    logic pre;
    send_frame(8'h3C, 1'b0, 1'b0, pre);
    checks++;
    if (frame_err !== 1'b1 || rdy !== 1'b0 || data !== 8'hA5) begin
      errors++;
      $display("FAIL ferr_flag: got fe %b rdy %b data %h, want 1 0 a5",
               frame_err, rdy, data);
    end
    rx = 1'b1;
    wait_ticks(24);
    checks++;
    if (frame_err !== 1'b1 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_sticky: got fe %b rdy %b, want 1 0",
               frame_err, rdy);
    end
    send_frame(8'h55, 1'b1, 1'b0, pre);
    checks++;
    if (data !== 8'h55 || rdy !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_recover: got %h rdy %b fe %b, want 55 1 0",
               data, rdy, frame_err);
    end
    finish_stop();
    pulse_clr();
  endtask

  task automatic test_overrun();
    logic pre;
    send_frame(8'h11, 1'b1, 1'b0, pre);
    checks++;
    if (data !== 8'h11 || rdy !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got %h rdy %b ov %b, want 11 1 0",
               data, rdy, overrun);
    end
    finish_stop();
    send_frame(8'h22, 1'b1, 1'b0, pre);
    checks++;
    if (data !== 8'h22 || rdy !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: got %h rdy %b ov %b, want 22 1 1",
               data, rdy, overrun);
    end
    finish_stop();
    pulse_clr();
    checks++;
    if (rdy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr: got rdy %b ov %b, want 0 0", rdy, overrun);
    end
  endtask

  task automatic test_clr_collision();
    logic pre;
    send_frame(8'h6B, 1'b1, 1'b0, pre);
    finish_stop();
    send_frame(8'h9E, 1'b1, 1'b1, pre);
    checks++;
    if (pre !== 1'b1) begin
      errors++;
      $display("FAIL coll_pre: got rdy %b, want 1", pre);
    end
    checks++;
    if (rdy !== 1'b1 || overrun !== 1'b0 || data !== 8'h9E) begin
      errors++;
      $display("FAIL coll_result: got rdy %b ov %b data %h, want 1 0 9e",
               rdy, overrun, data);
    end
    finish_stop();
    pulse_clr();
  endtask

  task automatic test_reset_midframe();
    logic pre;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      wait_ticks(16);
    end
    rx = 1'b0;
    wait_ticks(8);
    rstn = 1'b0;
    #1;
    checks++;
    if ({data, rdy, frame_err, overrun} !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h, want 0",
               {data, rdy, frame_err, overrun});
    end
    repeat (3) @(posedge clk_50m);
    rx = 1'b1;
    #1 rstn = 1'b1;
    wait_ticks(20);
    send_frame(8'h81, 1'b1, 1'b0, pre);
    checks++;
    if (data !== 8'h81 || rdy !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: got %h rdy %b fe %b, want 81 1 0",
               data, rdy, frame_err);
    end
    finish_stop();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_clr_collision();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
